dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the core MEM stage and an auxiliary
//   requester (loader/DMA/debug), with fixed core priority plus anti-starvation.
//   Sits between the MEM stage and dmem; core_stall feeds hazard_ctrl to freeze the pipeline.
// PARAMETERS
//   DWIDTH      32  data/address width
//   MEM_SIZE    64  dmem depth in words; aux byte addresses >= MEM_SIZE*4 are out of range
//   STARVE_MAX  8   aux wait cycles (1..255) before ownership is forced to aux
//   MAX_BURST   4   aux beats (1..255) before ownership returns to a pending core
// PORTS
//   clk             in   1       clock
//   rst             in   1       synchronous reset, active-low
//   c_req           in   1       core MEM-stage access request (load or store)
//   c_we            in   1       core write enable
//   c_addr          in   DWIDTH  core byte address
//   c_wdata         in   DWIDTH  core write data
//   c_rdata         out  DWIDTH  core read data (combinational from dmem)
//   core_stall      out  1       1 = core access not granted this cycle; hold MEM stage
//   a_req           in   1       aux beat request; held until a_gnt
//   a_we            in   1       aux write enable
//   a_last          in   1       final beat of aux burst
//   a_addr          in   DWIDTH  aux byte address
//   a_wdata         in   DWIDTH  aux write data
//   a_gnt           out  1       aux beat accepted this cycle
//   a_rdata         out  DWIDTH  aux read data, valid when a_gnt
//   a_err           out  1       with a_gnt: address out of range, write suppressed, a_rdata=0
//   m_addr          out  DWIDTH  dmem address
//   m_we            out  1       dmem write enable
//   m_wdata         out  DWIDTH  dmem write data
//   m_rdata         in   DWIDTH  dmem read data (combinational)
//   perf_stall_cnt  out  32      core stall cycle count (see CONFIGURATION)
//   perf_aux_cnt    out  32      aux beat count (see CONFIGURATION)
// BEHAVIOUR
//   - Registered owner FSM: OWN_CORE (reset state), OWN_AUX. Grants follow the owner of
//     the current cycle; a switch takes effect the cycle after the decision.
//   - OWN_CORE: core_stall=0, a_gnt=0, dmem driven from c_* (m_we=c_req&c_we).
//     -> OWN_AUX when a_req && (!c_req || starve_cnt==STARVE_MAX).
//   - starve_cnt (8b): +1 per cycle with owner==OWN_CORE && a_req && c_req;
//     saturates at STARVE_MAX; cleared on entry to OWN_AUX or when a_req==0.
//   - OWN_AUX: a_gnt=a_req; core_stall=c_req; dmem driven from a_* (m_we=a_req&a_we&~oob).
//     beat_cnt (8b) +1 per granted beat, cleared on entry to OWN_AUX.
//     -> OWN_CORE after a granted beat with a_last, when a_req==0, or when
//        c_req && beat_cnt+1==MAX_BURST on a granted beat. Otherwise stay.
//   - oob = a_addr >= MEM_SIZE*4: a_err=1, a_rdata=0, m_we=0. Otherwise a_err=0.
//   - c_rdata = m_rdata when owner==OWN_CORE, else 0. a_rdata = m_rdata when a_gnt&~oob, else 0.
//   - Read latency 0 (same cycle); write commits at the next clk edge.
//   - Simultaneous a_last and MAX_BURST: single return to OWN_CORE, no double count.
//   - Reset (rst==0), including mid-burst: owner=OWN_CORE, counters=0; m_we forced 0 in
//     every rst==0 cycle; a_gnt=0, core_stall=0, a_err=0.
//   - c_we with c_req==0 never writes. Aux requester must hold a_* stable until a_gnt.
// CONFIGURATION
//   DMEM_ARB_PERF_EN defined: perf_stall_cnt +1 per cycle with core_stall=1;
//     perf_aux_cnt +1 per a_gnt cycle; both 32b wrap-around, cleared by reset.
//   Not defined: no counter flops; both perf ports tied to 0.
// TESTING
//   1. c_req pulses only, a_req=0 -> owner stays OWN_CORE, core_stall=0, m_* = c_* every cycle.
//   2. a_req=1 with a_last on beat 3, c_req=0 -> switch 1 cycle later, 3 a_gnt cycles, back to OWN_CORE.
//   3. c_req=1 continuous, a_req=1, STARVE_MAX=8 -> a_gnt first at cycle 10; core_stall=1
//      for 4 beats (MAX_BURST=4), then owner returns to OWN_CORE.
//   4. Aux write a_addr=0x100 (MEM_SIZE=64) -> a_gnt=1, a_err=1, m_we=0, dmem unchanged;
//      aux write 0x0FC data 0xDEADBEEF -> core load 0x0FC returns 0xDEADBEEF.
//   5. rst=0 during beat 2 of a 4-beat aux burst -> that cycle m_we=0, a_gnt=0;
//      after release owner=OWN_CORE, starve_cnt=0, beat_cnt=0.
//   6. With DMEM_ARB_PERF_EN: test 3 -> perf_stall_cnt=4, perf_aux_cnt=4; without: both 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/aux data memory arbiter with core priority and anti-starvation
// Optional DMEM_ARB_PERF_EN adds stall and aux-beat performance counters.
module dmem_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int MEM_SIZE   = 64,
  parameter int STARVE_MAX = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [DWIDTH-1:0] c_addr,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic [DWIDTH-1:0] c_rdata,
  output logic              core_stall,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_last,
  input  logic [DWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              a_err,
  output logic [DWIDTH-1:0] m_addr,
  output logic              m_we,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic [DWIDTH-1:0] m_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_aux_cnt
);

  typedef enum logic {OWN_CORE, OWN_AUX} owner_t;

  localparam logic [DWIDTH-1:0] AUX_LIMIT  = DWIDTH'(MEM_SIZE * 4);
  localparam logic [7:0]        STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0]        BURST_LIM  = 8'(MAX_BURST);

  owner_t     owner;
  logic [7:0] starve_cnt;
  logic [7:0] beat_cnt;
  logic       oob;
  logic       aux_own;

  assign oob     = a_addr >= AUX_LIMIT;
  assign aux_own = owner == OWN_AUX;

  // Datapath follows the current owner; every strobe is masked while reset is held.
  always_comb begin
    a_gnt      = rst & aux_own & a_req;
    core_stall = rst & aux_own & c_req;
    a_err      = a_gnt & oob;
    m_addr     = aux_own ? a_addr : c_addr;
    m_wdata    = aux_own ? a_wdata : c_wdata;
    m_we       = rst & (aux_own ? (a_req & a_we & ~oob) : (c_req & c_we));
    c_rdata    = aux_own ? '0 : m_rdata;
    a_rdata    = (a_gnt & ~oob) ? m_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner      <= OWN_CORE;
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      case (owner)
        OWN_CORE: begin
          if (a_req && (!c_req || starve_cnt == STARVE_LIM)) begin
            owner      <= OWN_AUX;
            starve_cnt <= '0;
            beat_cnt   <= '0;
          end else if (!a_req) begin
            starve_cnt <= '0;
          end else if (c_req && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        OWN_AUX: begin
          if (!a_req) begin
            owner <= OWN_CORE;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            // a_last and a full burst coinciding still yields one hand-back.
            if (a_last || (c_req && (beat_cnt + 8'd1) == BURST_LIM))
              owner <= OWN_CORE;
          end
        end
        default: owner <= OWN_CORE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] aux_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      aux_q   <= '0;
    end else begin
      if (core_stall) stall_q <= stall_q + 32'd1;
      if (a_gnt)      aux_q   <= aux_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_aux_cnt   = aux_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_aux_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, a_req, a_we, a_last;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic [31:0] c_rdata, a_rdata, m_addr, m_wdata, m_rdata;
  logic        core_stall, a_gnt, a_err, m_we;
  logic [31:0] perf_stall_cnt, perf_aux_cnt;

  logic [31:0] mem [64] = '{default: 32'h0};

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .core_stall(core_stall),
    .a_req(a_req), .a_we(a_we), .a_last(a_last), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_err(a_err),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_aux_cnt(perf_aux_cnt)
  );

  // Single-port memory: combinational read, write at the clock edge.
  assign m_rdata = mem[m_addr[7:2]];
  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    a_req = 0; a_we = 0; a_last = 0; a_addr = 0; a_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1;
  endtask

  task automatic core_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    c_req = 1; c_we = 0; c_addr = addr; a_req = 0;
    @(negedge clk);
    check(tag, c_rdata, exp);
    next_cycle();
  endtask

  // One single-beat aux access from core-owned idle: grant expected on the second cycle.
  task automatic aux_one(input logic [31:0] addr, input logic we, input logic [31:0] data,
                         input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int k;
    c_req = 0; a_req = 1; a_we = we; a_last = 1; a_addr = addr; a_wdata = data;
    for (k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_gnt) break;
      next_cycle();
    end
    check({tag, "_wait"}, k, 1);
    if (k < 4) begin
      check({tag, "_err"}, a_err, exp_err);
      check({tag, "_mwe"}, m_we, we & ~exp_err);
      check({tag, "_rdata"}, a_rdata, exp_rd);
      next_cycle();
    end
    a_req = 0; a_last = 0;
  endtask

  initial begin
    int beats;
    logic exp_g;

    // Reset with every request active and an out-of-range aux address.
    rst = 0;
    idle_inputs();
    c_req = 1; c_we = 1; c_wdata = 32'h1;
    a_req = 1; a_we = 1; a_addr = 32'h100;
    @(negedge clk);
    check("rst_mwe", m_we, 0);
    check("rst_gnt", a_gnt, 0);
    check("rst_stall", core_stall, 0);
    check("rst_err", a_err, 0);
    check("rst_perf_stall", perf_stall_cnt, 0);
    check("rst_perf_aux", perf_aux_cnt, 0);
    next_cycle();
    idle_inputs();
    next_cycle();
    rst = 1;

    // Core-only traffic passes straight through.
    c_req = 1; c_we = 1; c_addr = 32'h0; c_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("t1_mwe", m_we, 1);
    check("t1_maddr", m_addr, 32'h0);
    check("t1_mwdata", m_wdata, 32'hA5A5A5A5);
    check("t1_stall", core_stall, 0);
    check("t1_gnt", a_gnt, 0);
    next_cycle();
    c_addr = 32'h10; c_wdata = 32'h11111111;
    @(negedge clk);
    check("t1_maddr2", m_addr, 32'h10);
    next_cycle();
    c_req = 0; c_we = 1; c_addr = 32'h14; c_wdata = 32'h22222222;
    @(negedge clk);
    check("t1_noreq_mwe", m_we, 0);
    next_cycle();
    core_read(32'h10, 32'h11111111, "t1_rd10");
    core_read(32'h14, 32'h0, "t1_rd14");

    // Uncontended 3-beat aux burst ending on a_last.
    c_req = 0; c_we = 0;
    beats = 0;
    for (int i = 0; i < 5; i++) begin
      a_req = (beats < 3); a_we = 1; a_last = (beats == 2);
      a_addr = 32'h20 + 32'(4 * beats); a_wdata = 32'hB0 + 32'(beats);
      exp_g = (i >= 1 && i <= 3);
      @(negedge clk);
      check($sformatf("t2_gnt%0d", i), a_gnt, exp_g);
      if (exp_g) check($sformatf("t2_maddr%0d", i), m_addr, 32'h20 + 32'(4 * beats));
      if (a_gnt) beats++;
      next_cycle();
    end
    core_read(32'h24, 32'hB1, "t2_rd24");

    // Starvation: core busy, aux forced in after STARVE_MAX, held for MAX_BURST beats.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      c_req = 1; c_we = 0; c_addr = 32'h20;
      a_req = (i <= 12); a_we = 0; a_last = 0; a_addr = 32'h28;
      exp_g = (i >= 9 && i <= 12);
      @(negedge clk);
      check($sformatf("t3_gnt%0d", i), a_gnt, exp_g);
      check($sformatf("t3_stall%0d", i), core_stall, exp_g);
      check($sformatf("t3_crd%0d", i), c_rdata, exp_g ? 32'h0 : 32'hB0);
      if (exp_g) check($sformatf("t3_ard%0d", i), a_rdata, 32'hB2);
      next_cycle();
    end
`ifdef DMEM_ARB_PERF_EN
    check("t3_perf_stall", perf_stall_cnt, 4);
    check("t3_perf_aux", perf_aux_cnt, 4);
`else
    check("t3_perf_stall", perf_stall_cnt, 0);
    check("t3_perf_aux", perf_aux_cnt, 0);
`endif

    // Out-of-range aux accesses are acknowledged with an error and never write.
    aux_one(32'h100, 1, 32'h12345678, 1, 32'h0, "t4_oobwr");
    aux_one(32'hFC, 1, 32'hDEADBEEF, 0, 32'h0, "t4_wrfc");
    aux_one(32'h100, 0, 32'h0, 1, 32'h0, "t4_oobrd");
    aux_one(32'hFC, 0, 32'h0, 0, 32'hDEADBEEF, "t4_rdfc");
    core_read(32'hFC, 32'hDEADBEEF, "t4_crdfc");
    core_read(32'h0, 32'hA5A5A5A5, "t4_crd0");

    // Reset lands on beat 2 of a 4-beat aux write burst.
    c_req = 0;
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 0;
      a_req = 1; a_we = 1; a_last = 0;
      a_addr = 32'h30 + 32'(4 * beats); a_wdata = 32'hC0 + 32'(beats);
      @(negedge clk);
      if (i == 2) begin
        check("t5_rst_mwe", m_we, 0);
        check("t5_rst_gnt", a_gnt, 0);
        check("t5_rst_stall", core_stall, 0);
      end else begin
        check($sformatf("t5_gnt%0d", i), a_gnt, i == 1);
      end
      if (a_gnt) beats++;
      next_cycle();
    end
    rst = 1;
    // After release, counters restart: full starvation delay and a full 4-beat burst.
    for (int i = 0; i < 15; i++) begin
      c_req = 1; c_we = 0; c_addr = 32'h34;
      a_req = (beats < 5); a_we = 1; a_last = (beats == 4);
      a_addr = 32'h30 + 32'(4 * beats); a_wdata = 32'hC0 + 32'(beats);
      exp_g = (i >= 9 && i <= 12);
      @(negedge clk);
      if (i == 0) check("t5_no_write", c_rdata, 32'h0);
      check($sformatf("t5b_gnt%0d", i), a_gnt, exp_g);
      check($sformatf("t5b_stall%0d", i), core_stall, exp_g);
      if (a_gnt) beats++;
      next_cycle();
    end
    core_read(32'h40, 32'hC4, "t5_rd40");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
